puf_challenge_sequencer: RTL and testbench

- Controller that sits directly upstream of the arbiter PUF core.
- Drives its pulse and 8-bit challenge inputs, and takes back its 1-bit response.
- Per request, fires RESP_W challenges derived from a seed and runs each challenge VOTE_N times.
- Majority-votes each bit and returns a RESP_W-bit response word plus an instability mask over a valid/ready handshake.

---
 rtl/puf_challenge_sequencer_pkg.sv | 24 ++
 rtl/puf_challenge_sequencer_sync2.sv | 30 +++
 rtl/puf_challenge_sequencer.sv | 208 ++++++++++++++++++++
 tb/tb_puf_challenge_sequencer.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/puf_challenge_sequencer_pkg.sv
// Package shared by the arbiter-PUF challenge sequencer.
// Contents:
//   - state_t: FSM state encoding (IDLE, ARM, FIRE, RELAX, DONE)
//   - DEF_CHAL_W / DEF_RESP_W: default challenge and response widths
//   - vote_threshold(): number of 1-votes needed for a majority of 1
package puf_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_ARM   = 3'd1,
      ST_FIRE  = 3'd2,
      ST_RELAX = 3'd3,
      ST_DONE  = 3'd4
   } state_t;

   localparam int DEF_CHAL_W = 8;
   localparam int DEF_RESP_W = 8;

   // Majority threshold for an odd number of trials.
   function automatic int vote_threshold(input int vote_n);
      return (vote_n + 1) / 2;
   endfunction

endpackage

// File: rtl/puf_challenge_sequencer_sync2.sv
// Two-flop synchronizer for the asynchronous PUF response bit.
// Ports:
//   clk   - destination clock
//   rst_n - asynchronous active-low reset; both stages clear to 0
//   d     - asynchronous input
//   q     - synchronized output
module puf_sync2 (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic meta_r;
   logic sync_r;

   // Two back-to-back flops give metastability time to resolve.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_r <= 1'b0;
         sync_r <= 1'b0;
      end else begin
         meta_r <= d;
         sync_r <= meta_r;
      end
   end

   assign q = sync_r;

endmodule

// File: rtl/puf_challenge_sequencer.sv
// Challenge sequencer for an arbiter PUF. For each request it launches
// RESP_W challenges (seed, seed+1, ...), runs each VOTE_N times, majority
// votes each response bit and returns the word plus an instability mask.
// Ports:
//   clk, rst_n          - clock, asynchronous active-low reset
//   start, seed         - request pulse (IDLE only) and base challenge
//   busy                - request in progress until handshake completes
//   pulse_o, challenge_o- registered launch pulse and challenge to the PUF
//   response_i          - raw asynchronous PUF response
//   resp_data           - voted response word (bit k <- challenge seed+k)
//   unstable_mask       - bit k set when votes for bit k disagreed
//   resp_valid, resp_ready - result handshake
module puf_challenge_sequencer
   import puf_pkg::*;
#(
   parameter int CHAL_W        = DEF_CHAL_W,
   parameter int RESP_W        = DEF_RESP_W,
   parameter int VOTE_N        = 5,
   parameter int SETTLE_CYCLES = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [CHAL_W-1:0] seed,
   output logic              busy,
   output logic              pulse_o,
   output logic [CHAL_W-1:0] challenge_o,
   input  logic              response_i,
   output logic [RESP_W-1:0] resp_data,
   output logic [RESP_W-1:0] unstable_mask,
   output logic              resp_valid,
   input  logic              resp_ready
);

   localparam int ST_W = $clog2(SETTLE_CYCLES);
   localparam int TR_W = $clog2(VOTE_N + 1);
   localparam int K_W  = (RESP_W > 1) ? $clog2(RESP_W) : 1;

   localparam logic [ST_W-1:0] SETTLE_LAST = ST_W'(SETTLE_CYCLES - 1);
   localparam logic [TR_W-1:0] TRIAL_LAST  = TR_W'(VOTE_N - 1);
   localparam logic [TR_W-1:0] VOTE_ALL    = TR_W'(VOTE_N);
   localparam logic [TR_W-1:0] VOTE_THR    = TR_W'(vote_threshold(VOTE_N));
   localparam logic [K_W-1:0]  K_LAST      = K_W'(RESP_W - 1);

   state_t            state_r;
   state_t            next_state_s;
   logic [ST_W-1:0]   settle_r;
   logic [TR_W-1:0]   trial_r;
   logic [TR_W-1:0]   ones_r;
   logic [K_W-1:0]    k_r;
   logic [K_W-1:0]    k_inc_s;
   logic [CHAL_W-1:0] seed_r;
   logic [RESP_W-1:0] data_r;
   logic [RESP_W-1:0] mask_r;
   logic              resp_sync_s;
   logic              settle_done_s;
   logic              vote_done_s;
   logic              bit_done_s;

   logic              pulse_r;
   logic [CHAL_W-1:0] chal_r;
   logic              busy_r;
   logic              valid_r;
   logic              pulse_next_s;
   logic [CHAL_W-1:0] chal_next_s;
   logic              busy_next_s;
   logic              valid_next_s;

   puf_sync2 u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (response_i),
      .q     (resp_sync_s)
   );

   assign settle_done_s = (settle_r == SETTLE_LAST);
   assign vote_done_s   = (trial_r == TRIAL_LAST);
   assign bit_done_s    = (k_r == K_LAST);
   assign k_inc_s       = k_r + K_W'(1);

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= next_state_s;
      end
   end

   // Next-state logic.
   always_comb begin
      next_state_s = state_r;
      case (state_r)
         ST_IDLE:  if (start) next_state_s = ST_ARM; else next_state_s = ST_IDLE;
         ST_ARM:   next_state_s = ST_FIRE;
         ST_FIRE:  if (settle_done_s) next_state_s = ST_RELAX; else next_state_s = ST_FIRE;
         ST_RELAX: begin
            if (!settle_done_s) begin
               next_state_s = ST_RELAX;
            end else if (vote_done_s && bit_done_s) begin
               next_state_s = ST_DONE;
            end else begin
               next_state_s = ST_ARM;
            end
         end
         ST_DONE:  if (resp_ready) next_state_s = ST_IDLE; else next_state_s = ST_DONE;
         default:  next_state_s = ST_IDLE;
      endcase
   end

   // Output decode: outputs are registered from the next state so that
   // pulse_o and challenge_o line up exactly with the FIRE/ARM periods.
   always_comb begin
      pulse_next_s = (next_state_s == ST_FIRE);
      busy_next_s  = (next_state_s != ST_IDLE);
      valid_next_s = (next_state_s == ST_DONE);
      chal_next_s  = chal_r;
      if ((state_r == ST_IDLE) && (next_state_s == ST_ARM)) begin
         chal_next_s = seed;
      end else if ((state_r == ST_RELAX) && (next_state_s == ST_ARM)) begin
         if (vote_done_s) begin
            chal_next_s = seed_r + CHAL_W'(k_inc_s);
         end else begin
            chal_next_s = seed_r + CHAL_W'(k_r);
         end
      end else begin
         chal_next_s = chal_r;
      end
   end

   // Output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pulse_r <= 1'b0;
         chal_r  <= {CHAL_W{1'b0}};
         busy_r  <= 1'b0;
         valid_r <= 1'b0;
      end else begin
         pulse_r <= pulse_next_s;
         chal_r  <= chal_next_s;
         busy_r  <= busy_next_s;
         valid_r <= valid_next_s;
      end
   end

   // Counters, vote accumulation and result word.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         settle_r <= {ST_W{1'b0}};
         trial_r  <= {TR_W{1'b0}};
         ones_r   <= {TR_W{1'b0}};
         k_r      <= {K_W{1'b0}};
         seed_r   <= {CHAL_W{1'b0}};
         data_r   <= {RESP_W{1'b0}};
         mask_r   <= {RESP_W{1'b0}};
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (start) begin
                  seed_r   <= seed;
                  settle_r <= {ST_W{1'b0}};
                  trial_r  <= {TR_W{1'b0}};
                  ones_r   <= {TR_W{1'b0}};
                  k_r      <= {K_W{1'b0}};
                  data_r   <= {RESP_W{1'b0}};
                  mask_r   <= {RESP_W{1'b0}};
               end
            end
            ST_ARM: settle_r <= {ST_W{1'b0}};
            ST_FIRE: begin
               if (settle_done_s) begin
                  // Sample at the end of the pulse, when the arbiter has settled.
                  settle_r <= {ST_W{1'b0}};
                  ones_r   <= ones_r + TR_W'(resp_sync_s);
               end else begin
                  settle_r <= settle_r + ST_W'(1);
               end
            end
            ST_RELAX: begin
               if (settle_done_s) begin
                  settle_r <= {ST_W{1'b0}};
                  if (!vote_done_s) begin
                     trial_r <= trial_r + TR_W'(1);
                  end else begin
                     data_r[k_r] <= (ones_r >= VOTE_THR);
                     mask_r[k_r] <= (ones_r != {TR_W{1'b0}}) && (ones_r != VOTE_ALL);
                     ones_r      <= {TR_W{1'b0}};
                     trial_r     <= {TR_W{1'b0}};
                     if (!bit_done_s) k_r <= k_inc_s;
                  end
               end else begin
                  settle_r <= settle_r + ST_W'(1);
               end
            end
            ST_DONE: settle_r <= {ST_W{1'b0}};
            default: settle_r <= {ST_W{1'b0}};
         endcase
      end
   end

   assign pulse_o       = pulse_r;
   assign challenge_o   = chal_r;
   assign busy          = busy_r;
   assign resp_valid    = valid_r;
   assign resp_data     = data_r;
   assign unstable_mask = mask_r;

endmodule

// File: tb/tb_puf_challenge_sequencer.sv
// Bench for puf_challenge_sequencer: directed requests against a small PUF
// model, with a scoreboard queue checked by a handshake monitor.
module tb_puf_challenge_sequencer;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start;
   logic [7:0] seed;
   logic       busy;
   logic       pulse_o;
   logic [7:0] challenge_o;
   logic       response_i;
   logic [7:0] resp_data;
   logic [7:0] unstable_mask;
   logic       resp_valid;
   logic       resp_ready;

   int n_vec = 0;
   int n_err = 0;

   logic [15:0] sb_q[$];        // {data, mask} expected per request
   logic [7:0]  chal_seen[$];   // challenge at each pulse rising edge
   int          pulse_cnt = 0;  // total pulse rising edges seen
   int          pulse_base = 0;
   int          mode = 0;       // 0: const 1, 1: challenge[0], 2: bit2 trials 1,3 -> 0
   logic        pulse_prev = 1'b0;

   always #5 clk = ~clk;

   puf_challenge_sequencer dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .start         (start),
      .seed          (seed),
      .busy          (busy),
      .pulse_o       (pulse_o),
      .challenge_o   (challenge_o),
      .response_i    (response_i),
      .resp_data     (resp_data),
      .unstable_mask (unstable_mask),
      .resp_valid    (resp_valid),
      .resp_ready    (resp_ready)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // PUF model: choose the response when a new launch pulse appears.
   always @(negedge clk) begin
      int idx;
      if (pulse_o && !pulse_prev) begin
         idx = pulse_cnt - pulse_base;
         chal_seen.push_back(challenge_o);
         case (mode)
            0: response_i = 1'b1;
            1: response_i = challenge_o[0];
            2: response_i = !((idx / 5 == 2) && ((idx % 5 == 1) || (idx % 5 == 3)));
            default: response_i = 1'b0;
         endcase
         pulse_cnt++;
      end
      pulse_prev = pulse_o;
   end

   // Monitor: a result is consumed whenever valid and ready are both high.
   always @(negedge clk) begin
      logic [15:0] exp;
      if (rst_n === 1'b1 && resp_valid === 1'b1 && resp_ready === 1'b1) begin
         if (sb_q.size() == 0) begin
            check("unexpected_result", 32'(resp_valid), 32'd0);
         end else begin
            exp = sb_q.pop_front();
            check("resp_data", 32'(resp_data), 32'(exp[15:8]));
            check("unstable_mask", 32'(unstable_mask), 32'(exp[7:0]));
         end
      end
   end

   // Issue one request and return at the negedge of the first DONE cycle.
   // cyc counts periods with the one after the start-sampling edge as 1.
   task automatic run_req(input logic [7:0] sd, input int md, input logic [7:0] exp_d,
                          input logic [7:0] exp_m, output int cyc);
      bit found;
      mode = md;
      pulse_base = pulse_cnt;
      sb_q.push_back({exp_d, exp_m});
      @(posedge clk); #1;
      start = 1'b1;
      seed  = sd;
      @(posedge clk); #1;
      start = 1'b0;
      seed  = ~sd;
      cyc   = 1;
      found = 1'b0;
      for (int i = 0; i < 1000; i++) begin
         @(negedge clk);
         if (i == 0) check("busy_after_start", 32'(busy), 32'd1);
         if (resp_valid) begin
            found = 1'b1;
            break;
         end
         cyc++;
      end
      check("result_timeout", 32'(found), 32'd1);
      check("pulse_count", 32'(pulse_cnt - pulse_base), 32'd40);
   endtask

   // After a handshake with ready already high: idle next cycle, data held.
   task automatic check_release(input logic [7:0] exp_d);
      @(negedge clk);
      check("valid_dropped", 32'(resp_valid), 32'd0);
      check("busy_dropped", 32'(busy), 32'd0);
      check("data_kept", 32'(resp_data), 32'(exp_d));
   endtask

   initial begin
      int cyc;
      int base;
      rst_n      = 1'b0;
      start      = 1'b1;
      seed       = 8'h00;
      resp_ready = 1'b1;
      response_i = 1'b0;

      // Reset held with start high: everything quiet.
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_pulse", 32'(pulse_o), 32'd0);
      check("rst_chal", 32'(challenge_o), 32'd0);
      check("rst_valid", 32'(resp_valid), 32'd0);
      check("rst_data", 32'(resp_data), 32'd0);
      check("rst_mask", 32'(unstable_mask), 32'd0);
      start = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      check("idle_after_rst", 32'(busy), 32'd0);

      // Constant-1 PUF, seed 0x00: timing and pulse count.
      run_req(8'h00, 0, 8'hFF, 8'h00, cyc);
      check("valid_cycle", 32'(cyc), 32'd361);
      check_release(8'hFF);
      repeat (20) @(negedge clk);
      check("single_request_busy", 32'(busy), 32'd0);
      check("single_request_pulses", 32'(pulse_cnt), 32'd40);

      // challenge[0] PUF, seed 0xFE: challenge wrap-around.
      base = chal_seen.size();
      run_req(8'hFE, 1, 8'hAA, 8'h00, cyc);
      for (int k = 0; k < 8; k++) begin
         check("chal_first", 32'(chal_seen[base + 5*k]), 32'(8'(8'hFE + k)));
         check("chal_last", 32'(chal_seen[base + 5*k + 4]), 32'(8'(8'hFE + k)));
      end
      check_release(8'hAA);

      // Two dissenting trials on bit 2.
      run_req(8'h40, 2, 8'hFF, 8'h04, cyc);
      check_release(8'hFF);

      // Consumer stalls 20 cycles while start toggles.
      @(posedge clk); #1;
      resp_ready = 1'b0;
      run_req(8'h01, 1, 8'h55, 8'h00, cyc);
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         start = ~start;
         seed  = 8'($urandom);
         @(negedge clk);
         check("stall_valid", 32'(resp_valid), 32'd1);
         check("stall_busy", 32'(busy), 32'd1);
         check("stall_data", 32'(resp_data), 32'h55);
      end
      @(posedge clk); #1;
      start      = 1'b0;
      resp_ready = 1'b1;
      @(negedge clk);
      check_release(8'h55);
      run_req(8'h5A, 0, 8'hFF, 8'h00, cyc);
      check_release(8'hFF);

      // Reset in the middle of a FIRE phase.
      @(posedge clk); #1;
      start = 1'b1;
      seed  = 8'h10;
      @(posedge clk); #1;
      start = 1'b0;
      for (int i = 0; i < 100 && !pulse_o; i++) @(negedge clk);
      check("pulse_before_abort", 32'(pulse_o), 32'd1);
      @(posedge clk); #2;
      rst_n = 1'b0;
      #1;
      check("abort_pulse", 32'(pulse_o), 32'd0);
      check("abort_busy", 32'(busy), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("abort_idle_busy", 32'(busy), 32'd0);
      check("abort_valid", 32'(resp_valid), 32'd0);
      check("abort_data", 32'(resp_data), 32'd0);
      run_req(8'h10, 1, 8'hAA, 8'h00, cyc);
      check("post_abort_cycle", 32'(cyc), 32'd361);
      check_release(8'hAA);

      check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
      $fatal(1);
   end

endmodule
